// File: rtl/multicycle_seq_pkg.sv
// Shared state encoding and defaults for the multi-cycle instruction sequencer.
package multicycle_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StFault  = 3'd7
  } state_e;

  localparam int unsigned MemTimeoutDefault = 16;
  localparam int unsigned CntWDefault       = 32;

  // States that own the memory port and therefore arm the watchdog.
  function automatic logic is_mem_phase(state_e s);
    return (s == StFetch) || (s == StMem);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-wait watchdog: counts stalled cycles and flags when the last allowed wait is reached.
module seq_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT);
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory watchdog and retire counter.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a HALT state before every fetch.
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
  parameter int unsigned CNT_W       = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             dec_mem_en,
  input  logic             dec_ls,
  input  logic             dec_reg_w,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             alu_en,
  output logic             rf_we,
  output logic             bus_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

`ifdef SEQ_SINGLE_STEP_EN
  localparam state_e NextInstr = StHalt;
`else
  localparam state_e NextInstr = StFetch;
`endif

  state_e           state_q, state_d;
  logic             retire;
  logic             wd_expired;
  logic [CNT_W-1:0] retired_q;

  seq_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d != state_q),
    .en_i     (is_mem_phase(state_q) && !mem_ready),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle:   state_d = NextInstr;
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (wd_expired) begin
          state_d = StFault;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (dec_mem_en) begin
          state_d = StMem;
        end else if (dec_reg_w) begin
          state_d = StWb;
        end else begin
          state_d = NextInstr;
          retire  = 1'b1;
        end
      end
      StMem: begin
        // A ready on the final allowed wait cycle still completes the transfer.
        if (mem_ready) begin
          if (dec_ls) begin
            state_d = StWb;
          end else begin
            state_d = NextInstr;
            retire  = 1'b1;
          end
        end else if (wd_expired) begin
          state_d = StFault;
        end
      end
      StWb: begin
        state_d = NextInstr;
        retire  = 1'b1;
      end
`ifdef SEQ_SINGLE_STEP_EN
      StHalt: begin
        if (step) begin
          state_d = StFetch;
        end
      end
`endif
      StFault:  state_d = StFault;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    mem_req = 1'b0;
    mem_sel = 1'b0;
    mem_we  = 1'b0;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    alu_en  = 1'b0;
    rf_we   = 1'b0;
    bus_err = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_inc  = mem_ready;
      end
      StExec:  alu_en = 1'b1;
      StMem: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = ~dec_ls;
      end
      StWb:    rf_we = 1'b1;
      StFault: bus_err = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: directed table, random instruction stream, corner sequences.
module tb_multicycle_seq;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dec_mem_en = 1'b0, dec_ls = 1'b0, dec_reg_w = 1'b0, mem_ready = 1'b0;
  logic          mem_req, mem_sel, mem_we, ir_load, pc_inc, alu_en, rf_we, bus_err;
  logic [2:0]    state_o;
  logic [CW-1:0] retired;
`ifdef SEQ_SINGLE_STEP_EN
  logic          step = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  multicycle_seq #(
    .MEM_TIMEOUT(TO),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .dec_mem_en(dec_mem_en),
    .dec_ls    (dec_ls),
    .dec_reg_w (dec_reg_w),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel),
    .mem_we    (mem_we),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .alu_en    (alu_en),
    .rf_we     (rf_we),
    .bus_err   (bus_err),
    .state_o   (state_o),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench timeout");
  end

  // {mem_req, mem_sel, mem_we, ir_load, pc_inc, alu_en, rf_we, bus_err, state}
  function automatic logic [10:0] mk(bit rq, bit sl, bit we, bit ld, bit al, bit rf, bit be,
                                     logic [2:0] st);
    return {rq, sl, we, ld, ld, al, rf, be, st};
  endfunction

  function automatic logic [10:0] act_word();
    return {mem_req, mem_sel, mem_we, ir_load, pc_inc, alu_en, rf_we, bus_err, state_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check the reset state, release, and land in the first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("reset_outputs", 32'(act_word()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 3'd0)));
    chk("reset_retired", 32'(retired), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = 0;
    next_cycle();
    chk("idle_to_fetch", 32'(state_o), 32'd1);
  endtask

  // Run one instruction from the first FETCH cycle; expected per-cycle trace is built from the
  // phase rules: fw+1 fetch cycles, decode, exec, optional mw+1 mem cycles, optional write-back.
  task automatic run_instr(input bit me, input bit ls, input bit rw, input int fw, input int mw,
                           output int rf_n, output int we_n);
    logic [10:0] q[$];
    int          mem_done;
    for (int i = 0; i <= fw; i++) q.push_back(mk(1, 0, 0, i == fw, 0, 0, 0, 3'd1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd2));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3'd3));
    if (me) for (int i = 0; i <= mw; i++) q.push_back(mk(1, 1, !ls, 0, 0, 0, 0, 3'd4));
    if ((me && ls) || (!me && rw)) q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3'd5));
    mem_done = fw + 3 + mw;
    dec_mem_en = me;
    dec_ls     = ls;
    dec_reg_w  = rw;
    rf_n = 0;
    we_n = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i <= fw) mem_ready = (i == fw);
      else if (me && i >= fw + 3 && i <= mem_done) mem_ready = (i == mem_done);
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("trace_cyc%0d", i), 32'(act_word()), 32'(q[i]));
      rf_n += int'(rf_we);
      we_n += int'(mem_we);
      next_cycle();
    end
    exp_ret = (exp_ret + 1) % (1 << CW);
    mem_ready = 1'b0;
    #1;
    chk("back_to_fetch", 32'(state_o), 32'd1);
    chk("retired_count", 32'(retired), 32'(exp_ret));
  endtask

  task automatic timeout_seq(input bit in_mem);
    dec_mem_en = 1'b1;
    dec_ls     = 1'b0;
    dec_reg_w  = 1'b0;
    if (in_mem) begin
      mem_ready = 1'b1;
      next_cycle();
      mem_ready = 1'b0;
      next_cycle();
      next_cycle();
    end
    for (int i = 0; i < int'(TO); i++) begin
      mem_ready = 1'b0;
      #1;
      chk($sformatf("wait_state%0d", i), 32'(state_o), in_mem ? 32'd4 : 32'd1);
      next_cycle();
    end
    #1;
    chk("fault_state", 32'(act_word()), 32'(mk(0, 0, 0, 0, 0, 0, 1, 3'd7)));
    mem_ready = 1'b1;
    repeat (3) next_cycle();
    chk("fault_sticky", 32'(act_word()), 32'(mk(0, 0, 0, 0, 0, 0, 1, 3'd7)));
    chk("fault_retired_frozen", 32'(retired), 32'(exp_ret));
  endtask

  typedef struct {
    bit me;
    bit ls;
    bit rw;
    int fw;
    int mw;
    int rf;
    int we;
  } vec_t;

  vec_t tbl[8];
  int   rf_n, we_n;

  initial begin
    tbl[0] = '{me: 0, ls: 0, rw: 1, fw: 0, mw: 0, rf: 1, we: 0};  // ALU with write-back
    tbl[1] = '{me: 0, ls: 0, rw: 0, fw: 0, mw: 0, rf: 0, we: 0};  // ALU, no write
    tbl[2] = '{me: 1, ls: 1, rw: 1, fw: 0, mw: 3, rf: 1, we: 0};  // load, 3-cycle stall
    tbl[3] = '{me: 1, ls: 0, rw: 0, fw: 2, mw: 0, rf: 0, we: 1};  // store, slow fetch
    tbl[4] = '{me: 1, ls: 0, rw: 1, fw: 0, mw: 2, rf: 0, we: 3};  // store ignores reg_w
    tbl[5] = '{me: 1, ls: 1, rw: 0, fw: 1, mw: 1, rf: 1, we: 0};  // load writes regardless
    tbl[6] = '{me: 0, ls: 0, rw: 1, fw: 3, mw: 0, rf: 1, we: 0};  // ready on last fetch wait
    tbl[7] = '{me: 1, ls: 1, rw: 1, fw: 3, mw: 3, rf: 1, we: 0};  // last wait in both phases

    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i].me, tbl[i].ls, tbl[i].rw, tbl[i].fw, tbl[i].mw, rf_n, we_n);
      chk($sformatf("tbl%0d_rf_we_cycles", i), 32'(rf_n), 32'(tbl[i].rf));
      chk($sformatf("tbl%0d_mem_we_cycles", i), 32'(we_n), 32'(tbl[i].we));
    end

    for (int i = 0; i < 30; i++) begin
      run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)), rf_n, we_n);
    end

    // Reset in the middle of a store must kill the strobe immediately.
    run_instr(1'b0, 1'b0, 1'b1, 0, 0, rf_n, we_n);
    dec_mem_en = 1'b1;
    dec_ls     = 1'b0;
    mem_ready  = 1'b1;
    next_cycle();
    mem_ready  = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    chk("mid_mem_store_active", 32'({mem_req, mem_we, state_o}), 32'({2'b11, 3'd4}));
    #1;
    rst = 1'b1;
    #1;
    chk("mid_mem_reset_outputs", 32'(act_word()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 3'd0)));
    chk("mid_mem_reset_retired", 32'(retired), 32'd0);
    next_cycle();
    rst = 1'b0;
    exp_ret = 0;
    next_cycle();
    chk("restart_fetch", 32'(state_o), 32'd1);

    // Counter wrap at 2^CW.
    for (int i = 0; i < 16; i++) begin
      run_instr(1'b0, 1'b0, 1'b1, 0, 0, rf_n, we_n);
      if (i == 14) chk("retired_15", 32'(retired), 32'd15);
    end
    chk("retired_wrap", 32'(retired), 32'd0);

    timeout_seq(1'b0);
    do_reset();
    run_instr(1'b0, 1'b0, 1'b0, 0, 0, rf_n, we_n);
    timeout_seq(1'b1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
